// File: rtl/dbus_mem_responder_if.sv
// Data-bus request/response bundle between the core (master) and a memory responder (slave).
interface dbus_mem_responder_if;
  logic        req_valid;
  logic [63:0] req_addr;
  logic [2:0]  req_size;
  logic [7:0]  req_strobe;
  logic [63:0] req_data;
  logic        resp_addr_ok;
  logic        resp_data_ok;
  logic [63:0] resp_data;

  modport master (
    output req_valid, req_addr, req_size, req_strobe, req_data,
    input  resp_addr_ok, resp_data_ok, resp_data
  );

  modport slave (
    input  req_valid, req_addr, req_size, req_strobe, req_data,
    output resp_addr_ok, resp_data_ok, resp_data
  );
endinterface

// File: rtl/dbus_mem_responder.sv
// Data-bus memory responder: 64-bit word array, programmable latency and backdoor preload.
// Optional random response stalls are enabled by defining DBUS_RESP_STALL_EN.
module dbus_mem_responder #(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  dbus_mem_responder_if.slave  dbus,
  input  logic                 ld_en_i,
  input  logic [63:0]          ld_addr_i,
  input  logic [63:0]          ld_data_i,
  output logic                 busy_o
);
  localparam int unsigned IW = $clog2(DEPTH);
`ifdef DBUS_RESP_STALL_EN
  localparam int unsigned CW = $clog2(LATENCY + 3);
`else
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
`endif

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [63:0]     addr_q, addr_d;
  logic [63:0]     data_q, data_d;
  logic [7:0]      strobe_q, strobe_d;
  logic [63:0]     mem_q [DEPTH];
  logic [CW-1:0]   stall;
  logic [IW-1:0]   idx, ldIdx;
  logic            inRange, respActive;
  logic [63:0]     rdData;
  logic            unusedBits;

`ifdef DBUS_RESP_STALL_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk_i) begin
    if (!reset_ni) lfsr_q <= 16'hACE1;
    else           lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  assign stall = CW'(lfsr_q[1:0]);
`else
  assign stall = '0;
`endif

  assign idx        = addr_q[IW+2:3];
  assign ldIdx      = ld_addr_i[IW+2:3];
  assign inRange    = (addr_q[63:IW+3] == '0);
  // A reset asserted during RESP suppresses both the response and the write.
  assign respActive = (state_q == RESP) && reset_ni;
  assign unusedBits = ^{dbus.req_size, ld_addr_i[63:IW+3], ld_addr_i[2:0], addr_q[2:0]};

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      strobe_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      strobe_q <= strobe_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    data_d   = data_q;
    strobe_d = strobe_q;
    unique case (state_q)
      IDLE: begin
        if (dbus.req_valid) begin
          state_d  = WAIT;
          cnt_d    = CW'(LATENCY - 1) + stall;
          addr_d   = dbus.req_addr;
          data_d   = dbus.req_data;
          strobe_d = dbus.req_strobe;
        end
      end
      WAIT: begin
        if (!dbus.req_valid)  state_d = IDLE;
        else if (cnt_q == '0) state_d = RESP;
        else                  cnt_d   = cnt_q - 1'b1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A backdoor load in the RESP cycle is forwarded so the read sees it.
  always_comb begin
    rdData = '0;
    if (inRange) begin
      if (ld_en_i && (ldIdx == idx)) rdData = ld_data_i;
      else                           rdData = mem_q[idx];
    end
  end

  assign dbus.resp_addr_ok = respActive;
  assign dbus.resp_data_ok = respActive;
  assign dbus.resp_data    = (respActive && (strobe_q == 8'h00)) ? rdData : 64'h0;
  assign busy_o            = (state_q != IDLE);

  // The backdoor assignment comes last so it wins over a same-word bus write.
  always_ff @(posedge clk_i) begin
    if (respActive && (strobe_q != 8'h00) && inRange) begin
      for (int i = 0; i < 8; i++) begin
        if (strobe_q[i]) mem_q[idx][8*i +: 8] <= data_q[8*i +: 8];
      end
    end
    if (ld_en_i) mem_q[ldIdx] <= ld_data_i;
  end
endmodule

// File: tb/tb_dbus_mem_responder.sv
// Self-checking bench for dbus_mem_responder: directed cases plus randomized traffic vs. a word-array model.
module tb_dbus_mem_responder;
  localparam int unsigned DEPTH   = 1024;
  localparam int unsigned LATENCY = 2;
  localparam int unsigned USED    = 64;

  logic        clk;
  logic        resetN;
  logic        ldEn;
  logic [63:0] ldAddr;
  logic [63:0] ldData;
  logic        busy;
  int          checks;
  int          errors;
  logic [63:0] model [DEPTH];

  dbus_mem_responder_if dbusIf ();

  dbus_mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk_i     (clk),
    .reset_ni  (resetN),
    .dbus      (dbusIf.slave),
    .ld_en_i   (ldEn),
    .ld_addr_i (ldAddr),
    .ld_data_i (ldData),
    .busy_o    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] modelRead(input logic [63:0] addr);
    if (addr < 64'(DEPTH) * 8) return model[int'(addr >> 3)];
    return 64'h0;
  endfunction

  function automatic void modelWrite(input logic [63:0] addr, input logic [7:0] strobe, input logic [63:0] data);
    if (addr < 64'(DEPTH) * 8) begin
      for (int i = 0; i < 8; i++) begin
        if (strobe[i]) model[int'(addr >> 3)][8*i +: 8] = data[8*i +: 8];
      end
    end
  endfunction

  task automatic loadWord(input logic [63:0] addr, input logic [63:0] data);
    ldEn = 1'b1; ldAddr = addr; ldData = data;
    @(posedge clk); #1;
    ldEn = 1'b0;
    model[int'(addr[12:3])] = data;
  endtask

  task automatic pulseReset();
    resetN = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    resetN = 1'b1;
  endtask

  // ldCycle: -1 none, 0 during the response cycle, N>0 that many cycles after the request is raised.
  task automatic applyStimulus(input logic [63:0] addr, input logic [7:0] strobe, input logic [63:0] wdata,
                               input int ldCycle, input logic [63:0] ldVal, input bit scramble,
                               output logic [63:0] rdata, output int lat);
    dbusIf.req_valid  = 1'b1;
    dbusIf.req_addr   = addr;
    dbusIf.req_size   = 3'd3;
    dbusIf.req_strobe = strobe;
    dbusIf.req_data   = wdata;
    lat   = -1;
    rdata = '0;
    for (int cyc = 1; cyc <= 20 && lat < 0; cyc++) begin
      @(posedge clk); #1;
      ldEn = 1'b0;
      if (cyc == 1) begin
        checkOutput("busyInWait", 64'(busy), 64'd1);
        if (scramble) begin
          dbusIf.req_addr   = {$urandom, $urandom};
          dbusIf.req_data   = {$urandom, $urandom};
          dbusIf.req_strobe = 8'($urandom);
        end
      end
      if (dbusIf.resp_data_ok) begin
        lat   = cyc;
        rdata = dbusIf.resp_data;
        checkOutput("addrOk", 64'(dbusIf.resp_addr_ok), 64'd1);
        if (ldCycle == 0) begin ldEn = 1'b1; ldAddr = addr; ldData = ldVal; end
      end
      if (ldCycle > 0 && ldCycle == cyc) begin ldEn = 1'b1; ldAddr = addr; ldData = ldVal; end
    end
    dbusIf.req_valid = 1'b0;
    @(posedge clk); #1;
    ldEn = 1'b0;
    checkOutput("dataOkPulse", 64'(dbusIf.resp_data_ok), 64'd0);
    if (lat < 0) checkOutput("timeout", 64'd0, 64'd1);
  endtask

  task automatic checkLatency(input int lat);
`ifdef DBUS_RESP_STALL_EN
    checkOutput("latencyRange", 64'(lat >= 3 && lat <= 6), 64'd1);
`else
    checkOutput("latency", 64'(lat), 64'(LATENCY + 1));
`endif
  endtask

  initial begin
    logic [63:0] rd, addr, wdata;
    logic [7:0]  strobe;
    int          lat, idx;
    bit          oor;

    checks = 0; errors = 0;
    ldEn = 1'b0; ldAddr = '0; ldData = '0;
    dbusIf.req_valid = 1'b0; dbusIf.req_addr = '0; dbusIf.req_size = '0;
    dbusIf.req_strobe = '0; dbusIf.req_data = '0;
    resetN = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    checkOutput("rstAddrOk", 64'(dbusIf.resp_addr_ok), 64'd0);
    checkOutput("rstDataOk", 64'(dbusIf.resp_data_ok), 64'd0);
    checkOutput("rstData",   dbusIf.resp_data,          64'd0);
    checkOutput("rstBusy",   64'(busy),                 64'd0);
    resetN = 1'b1;

    for (int i = 0; i < int'(USED); i++) loadWord(64'(i) * 8, {$urandom, $urandom});

    // Preloaded read with fixed latency, then retained across a reset.
    loadWord(64'h10, 64'hDEAD_BEEF_0123_4567);
    applyStimulus(64'h10, 8'h00, 64'h0, -1, 64'h0, 1'b0, rd, lat);
    checkOutput("preloadRead", rd, 64'hDEAD_BEEF_0123_4567);
    checkLatency(lat);
    pulseReset();
    applyStimulus(64'h10, 8'h00, 64'h0, -1, 64'h0, 1'b0, rd, lat);
    checkOutput("memAfterReset", rd, 64'hDEAD_BEEF_0123_4567);

    applyStimulus(64'h10, 8'h0F, 64'h1111_2222_3333_4444, -1, 64'h0, 1'b0, rd, lat);
    checkOutput("writeRespData", rd, 64'h0);
    modelWrite(64'h10, 8'h0F, 64'h1111_2222_3333_4444);
    applyStimulus(64'h10, 8'h00, 64'h0, -1, 64'h0, 1'b0, rd, lat);
    checkOutput("partialWrite", rd, 64'hDEAD_BEEF_3333_4444);

    applyStimulus(64'h2000, 8'h00, 64'h0, -1, 64'h0, 1'b0, rd, lat);
    checkOutput("oorRead", rd, 64'h0);
    applyStimulus(64'h2000, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, -1, 64'h0, 1'b0, rd, lat);
    checkOutput("oorWriteResp", 64'(lat > 0), 64'd1);
    applyStimulus(64'h0, 8'h00, 64'h0, -1, 64'h0, 1'b0, rd, lat);
    checkOutput("oorWriteDropped", rd, modelRead(64'h0));

    // Abort by dropping valid in WAIT.
    dbusIf.req_valid = 1'b1; dbusIf.req_addr = 64'h10;
    dbusIf.req_strobe = 8'hFF; dbusIf.req_data = 64'hAAAA_AAAA_AAAA_AAAA;
    @(posedge clk); #1;
    checkOutput("abortBusyWait", 64'(busy), 64'd1);
    dbusIf.req_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("abortBusy", 64'(busy), 64'd0);
    for (int i = 0; i < 6; i++) begin
      checkOutput("abortNoResp", 64'(dbusIf.resp_data_ok), 64'd0);
      @(posedge clk); #1;
    end
    applyStimulus(64'h10, 8'h00, 64'h0, -1, 64'h0, 1'b0, rd, lat);
    checkOutput("abortNoWrite", rd, 64'hDEAD_BEEF_3333_4444);

    // Reset asserted in WAIT.
    dbusIf.req_valid = 1'b1; dbusIf.req_addr = 64'h10;
    dbusIf.req_strobe = 8'hFF; dbusIf.req_data = 64'h5555_5555_5555_5555;
    @(posedge clk); #1;
    resetN = 1'b0;
    @(posedge clk); #1;
    checkOutput("rstWaitBusy", 64'(busy), 64'd0);
    resetN = 1'b1; dbusIf.req_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checkOutput("rstWaitNoResp", 64'(dbusIf.resp_data_ok), 64'd0);
      @(posedge clk); #1;
    end
    applyStimulus(64'h10, 8'h00, 64'h0, -1, 64'h0, 1'b0, rd, lat);
    checkOutput("rstWaitNoWrite", rd, 64'hDEAD_BEEF_3333_4444);

    // Backdoor beats a same-cycle bus write; a load during WAIT is seen by the read.
    applyStimulus(64'h18, 8'hFF, 64'h1234_1234_1234_1234, 0, 64'hCAFE_F00D_0000_0001, 1'b0, rd, lat);
    modelWrite(64'h18, 8'hFF, 64'h1234_1234_1234_1234);
    model[3] = 64'hCAFE_F00D_0000_0001;
    applyStimulus(64'h18, 8'h00, 64'h0, -1, 64'h0, 1'b0, rd, lat);
    checkOutput("ldPriority", rd, 64'hCAFE_F00D_0000_0001);
    applyStimulus(64'h20, 8'h00, 64'h0, 1, 64'h0BAD_C0DE_7777_8888, 1'b0, rd, lat);
    model[4] = 64'h0BAD_C0DE_7777_8888;
    checkOutput("ldDuringWait", rd, 64'h0BAD_C0DE_7777_8888);

    for (int n = 0; n < 1000; n++) begin
      idx   = int'($urandom_range(0, USED - 1));
      oor   = ($urandom_range(0, 9) == 0);
      addr  = 64'(idx) * 8 + 64'($urandom_range(0, 7));
      if (oor) addr = addr | (64'd1 << $urandom_range(13, 63));
      strobe = ($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom);
      wdata  = {$urandom, $urandom};
      applyStimulus(addr, strobe, wdata, -1, 64'h0, 1'b1, rd, lat);
      if (strobe == 8'h00) checkOutput("randRead", rd, modelRead(addr));
      else begin
        checkOutput("randWriteResp", rd, 64'h0);
        modelWrite(addr, strobe, wdata);
      end
      checkLatency(lat);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
